tdm_demux4: RTL
===============

Name: tdm_demux4

Overview:
- Time-division demultiplexer: receives a stream of WIDTH-bit samples produced by a 4:1 mux stepping its select 00→01→10→11 and rebuilds the four parallel channels I[3:0].
- Sits on the receive end of a TDM link and drives downstream parallel logic with whole, aligned frames.
- Frame alignment uses a start-of-frame marker on slot 0.
- Includes sync-loss detection and re-hunting.

Parameters:
- WIDTH, 1, bit width of each channel sample; the frame is 4*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low. Sampled only on the rising edge of clk.
- din  input  WIDTH  incoming TDM sample.
- din_valid  input  1  din is valid this cycle. Idle cycles hold state.
- sof  input  1  start of frame; qualified by din_valid; marks din as slot 0.
- I  output  4*WIDTH  last complete frame. Channel k occupies I[k*WIDTH +: WIDTH].
- frame_valid  output  1  one-cycle pulse: I was updated on this edge.
- s  output  2  slot index expected for the next valid sample.
- locked  output  1  high while in COLLECT.
- sync_err  output  1  one-cycle pulse on an alignment violation.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - I=0, frame_valid=0, s=0, locked=0, sync_err=0.
  - Shadow registers cleared; FSM enters HUNT.
  - Reset asserted mid-frame discards the partial frame. I is cleared in the same edge.
- FSM states: HUNT, COLLECT.
- HUNT:
  - Samples are ignored until din_valid&sof.
  - On din_valid&sof: shadow[0]<=din, s<=1, go COLLECT.
  - din_valid without sof: discarded silently, no sync_err.
- COLLECT, on each din_valid cycle:
  - sof=1 and s!=0: sync_err pulse. Partial frame discarded. shadow[0]<=din, s<=1. Stay COLLECT (resync).
  - sof=0 and s==0: sync_err pulse. Go HUNT, s<=0, sample discarded.
  - Otherwise: shadow[s]<=din, s<=s+1 (2-bit wrap, 11→00).
  - When s==3 on that edge: I<={din, shadow[2], shadow[1], shadow[0]} and frame_valid=1 for one cycle.
- din_valid=0 in any state:
  - No state change; s holds.
  - frame_valid and sync_err are deasserted.
- Latency: I and frame_valid are visible in the cycle after the edge that samples slot 3. I holds until the next complete frame or reset.
- Priority: rst_n > sync checks > normal collection.
- Partial frames never reach I.
- Back-to-back frames need no gap. A slot-0 sof immediately after slot 3 continues in COLLECT, giving one frame per 4 valid cycles.
- No arithmetic beyond the 2-bit slot counter. All channel widths are exactly WIDTH; no truncation.
- frame_valid and sync_err are never high together.

Test Plan:
- Reset then frame (WIDTH=1): rst_n=0 for 2 cycles, then the valid sequence din=0,1,0,0 with sof on the first sample → one cycle after the 4th sample: I=4'b0010, frame_valid pulses once, locked=1, s=0.
- Gapped stream: the same 4 samples 1,0,0,0 with 3 idle cycles between each → I=4'b0001 after the last sample; s holds through the gaps; no sync_err.
- Back-to-back frames: frames {0,0,1,0} then {0,0,0,1} (sof on each first sample) → frame_valid on the 4th and 8th samples; I=4'b0100, then 4'b1000.
- Early sof: sof asserted at s=2 with din=1, followed by 0,0,0 → sync_err one pulse; the next frame completes with I=4'b0001; the old partial frame is never visible.
- Missing sof: in COLLECT at s=0, din_valid=1 with sof=0 → sync_err pulse, locked=0, s=0. Later samples are ignored until sof.
- Reset mid-frame: assert rst_n=0 after 2 samples → I=0, s=0, locked=0. After reset, a full frame with sof is needed before frame_valid.

Source files
------------

// File: rtl/tdm_demux4_if.sv
// Receive-side TDM bus: serial sample stream in, rebuilt parallel frame and link status out.
interface tdm_demux4_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0]   din;
  logic               din_valid;
  logic               sof;
  logic [4*WIDTH-1:0] I;
  logic               frame_valid;
  logic [1:0]         s;
  logic               locked;
  logic               sync_err;

  modport master (
    output din, din_valid, sof,
    input  I, frame_valid, s, locked, sync_err
  );

  modport slave (
    input  din, din_valid, sof,
    output I, frame_valid, s, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer: aligns on sof at slot 0, rebuilds whole frames,
// flags alignment violations and re-hunts when the marker goes missing.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input logic          clk,
  input logic          rst_n,
  tdm_demux4_if.slave  bus
);

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              slot, slot_nxt;
  logic [2:0][WIDTH-1:0]   shadow, shadow_nxt;
  logic [4*WIDTH-1:0]      frame, frame_nxt;
  logic                    fv, fv_nxt;
  logic                    se, se_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= HUNT;
      slot   <= '0;
      shadow <= '0;
      frame  <= '0;
      fv     <= 1'b0;
      se     <= 1'b0;
    end else begin
      state  <= state_nxt;
      slot   <= slot_nxt;
      shadow <= shadow_nxt;
      frame  <= frame_nxt;
      fv     <= fv_nxt;
      se     <= se_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot;
    shadow_nxt = shadow;
    frame_nxt  = frame;
    fv_nxt     = 1'b0;
    se_nxt     = 1'b0;

    if (bus.din_valid) begin
      unique case (state)
        HUNT: begin
          if (bus.sof) begin
            shadow_nxt[0] = bus.din;
            slot_nxt      = 2'd1;
            state_nxt     = COLLECT;
          end
        end

        COLLECT: begin
          if (bus.sof && slot != 2'd0) begin
            // Resync: the new marker wins, the partial frame is overwritten before it can be used.
            se_nxt        = 1'b1;
            shadow_nxt[0] = bus.din;
            slot_nxt      = 2'd1;
          end else if (!bus.sof && slot == 2'd0) begin
            se_nxt    = 1'b1;
            slot_nxt  = 2'd0;
            state_nxt = HUNT;
          end else begin
            slot_nxt = slot + 2'd1;
            unique case (slot)
              2'd0: shadow_nxt[0] = bus.din;
              2'd1: shadow_nxt[1] = bus.din;
              2'd2: shadow_nxt[2] = bus.din;
              2'd3: begin
                frame_nxt = {bus.din, shadow[2], shadow[1], shadow[0]};
                fv_nxt    = 1'b1;
              end
            endcase
          end
        end

        default: state_nxt = HUNT;
      endcase
    end
  end

  assign bus.I           = frame;
  assign bus.frame_valid = fv;
  assign bus.s           = slot;
  assign bus.locked      = (state == COLLECT);
  assign bus.sync_err    = se;

endmodule
